// File: rtl/float24_pkg.sv
// Shared float24 format definitions: field layout, exponent bias and PCM limits.
// Used by the arithmetic core and by the I2S transmitter.
package float24_pkg;

    localparam int EXP_W    = 7;
    localparam int FRAC_W   = 16;
    localparam int EXP_BIAS = 63;
    localparam int PCM_W    = 24;

    localparam logic [PCM_W-1:0] PCM_MAX = 24'h7FFFFF;
    localparam logic [PCM_W-1:0] PCM_MIN = 24'h800000;

    localparam int SIGN_BIT = 23;
    localparam int EXP_HI   = 22;
    localparam int EXP_LO   = 16;
    localparam int FRAC_HI  = 15;
    localparam int FRAC_LO  = 0;

    // Exponent at or above which |x| >= 1.0 and the Q1.23 result saturates.
    localparam logic [EXP_W-1:0] EXP_SAT   = 7'(EXP_BIAS);
    // Exponent where the 17-bit mantissa lines up with Q1.23 without shifting.
    localparam logic [EXP_W-1:0] EXP_UNITY = 7'(EXP_BIAS - (PCM_W - 1) + FRAC_W);

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } float24_t;

endpackage

// File: rtl/float24_to_pcm24.sv
// Combinational float24 -> signed Q1.23 PCM conversion with saturation and
// truncation toward zero.
module float24_to_pcm24
    import float24_pkg::*;
(
    input  logic [PCM_W-1:0] float_in,
    input  logic             underflow,
    input  logic             overflow,
    output logic [PCM_W-1:0] pcm
);

    float24_t         f;
    logic [PCM_W-1:0] m17;
    logic [PCM_W-1:0] mag;
    logic [PCM_W-1:0] sat;

    always_comb begin
        f   = float_in;
        m17 = {{(PCM_W-FRAC_W-1){1'b0}}, 1'b1, f.frac};
        sat = f.sign ? PCM_MIN : PCM_MAX;
        mag = '0;
        pcm = '0;
        if (overflow) begin
            pcm = sat;
        end else if (underflow || (f.exp == '0)) begin
            pcm = '0;
        end else if (f.exp >= EXP_SAT) begin
            pcm = sat;
        end else begin
            // Right shifts of 17 or more fall off the end and give zero.
            if (f.exp >= EXP_UNITY)
                mag = m17 << (f.exp - EXP_UNITY);
            else
                mag = m17 >> (EXP_UNITY - f.exp);
            pcm = f.sign ? (~mag + 24'd1) : mag;
        end
    end

endmodule

// File: rtl/float24_i2s_tx.sv
// I2S transmitter: accepts float24 samples, converts them to Q1.23 PCM and
// shifts them out MSB first on both slots with self-generated bclk/lrck.
module float24_i2s_tx
    import float24_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PCM_W-1:0] float_in,
    input  logic             float_in_underflow,
    input  logic             float_in_overflow,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             bclk,
    output logic             lrck,
    output logic             sdata,
    output logic             underrun
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [5:0]       bit_cnt_q, bit_cnt_d;
    logic             lrck_q, lrck_d;
    logic             sdata_q, sdata_d;
    logic             underrun_q, underrun_d;
    logic [PCM_W-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [PCM_W-1:0] frame_q, frame_d;

    logic [PCM_W-1:0] pcm_conv;
    logic             accept;
    logic             div_wrap;
    logic             shift_evt;
    logic             frame_wrap;
    logic [5:0]       bit_cnt_nxt;
    logic [4:0]       slot_k;
    logic [PCM_W-1:0] frame_sh;

    float24_to_pcm24 u_conv (
        .float_in  (float_in),
        .underflow (float_in_underflow),
        .overflow  (float_in_overflow),
        .pcm       (pcm_conv)
    );

    // Handshake: a sample transfers on any clk where in_valid && in_ready;
    // in_ready depends only on the hold register, never on in_valid.
    assign in_ready = !hold_full_q;
    assign accept   = in_valid && in_ready;

    assign div_wrap    = (div_q == DIV_W'(CLK_DIV - 1));
    assign shift_evt   = div_wrap && bclk_q;
    assign bit_cnt_nxt = bit_cnt_q + 6'd1;
    assign frame_wrap  = shift_evt && (bit_cnt_q == 6'd63);
    assign slot_k      = bit_cnt_nxt[4:0];
    assign frame_sh    = frame_q << (slot_k - 5'd1);

    always_comb begin
        div_d       = div_wrap ? '0 : div_q + 1'b1;
        bclk_d      = div_wrap ? ~bclk_q : bclk_q;
        bit_cnt_d   = bit_cnt_q;
        lrck_d      = lrck_q;
        sdata_d     = sdata_q;
        underrun_d  = 1'b0;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        frame_d     = frame_q;

        if (accept) begin
            hold_d      = pcm_conv;
            hold_full_d = 1'b1;
        end

        if (shift_evt) begin
            bit_cnt_d = bit_cnt_nxt;
            lrck_d    = bit_cnt_nxt[5];
            // Bit slot 0 of each half carries the I2S one-bclk delay.
            sdata_d   = (slot_k >= 5'd1 && slot_k <= 5'd24) ? frame_sh[PCM_W-1] : 1'b0;
            if (frame_wrap) begin
                if (hold_full_q) begin
                    frame_d     = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    underrun_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            bit_cnt_q   <= '0;
            lrck_q      <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            frame_q     <= '0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            bit_cnt_q   <= bit_cnt_d;
            lrck_q      <= lrck_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            frame_q     <= frame_d;
        end
    end

    assign bclk     = bclk_q;
    assign lrck     = lrck_q;
    assign sdata    = sdata_q;
    assign underrun = underrun_q;

endmodule
